// File: rtl/udp_frag_reassemble.sv
// Rebuilds UDP payload frames from headered sub-frames; each byte waits in H until its successor or a last mark arrives.
// Backpressure: s_tready drops only when H must move into a blocked output register or a blocked length slot.
module udp_frag_reassemble #(
    parameter int NMAX = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        length_tvalid,
    input  logic        length_tready,
    output logic [15:0] length_tdata,
    output logic [15:0] drop_count
);

    localparam int SCW = $clog2(NMAX);
    localparam logic [SCW-1:0] SC_LAST = SCW'(NMAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        FIRST_SEQ,
        BODY,
        CONT_SRC,
        CONT_SEQ,
        DISCARD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic           r_h_vld;
    logic           r_h_last;
    logic           r_h_user;
    logic [7:0]     r_h_dat;
    logic           r_o_vld;
    logic           r_o_last;
    logic           r_o_user;
    logic [7:0]     r_o_dat;
    logic           r_len_vld;
    logic [15:0]    r_len_dat;
    logic [15:0]    r_drop;
    logic [SCW-1:0] r_sc;
    logic [15:0]    r_fc;
    logic [7:0]     r_exp_seq;
    logic [7:0]     r_src;

    logic w_o_free;
    logic w_len_free;
    logic w_h_pend;
    logic w_h_flush;
    logic w_fwd_state;
    logic w_s_rdy;
    logic w_acc;
    logic w_h_to_o;

    logic w_push;
    logic w_push_last;
    logic w_abort;
    logic w_drop_h;
    logic w_drop_inc;
    logic w_start;
    logic w_seq_init;
    logic w_seq_inc;

    assign w_o_free    = !r_o_vld || m_tready;
    assign w_len_free  = !r_len_vld || length_tready;
    assign w_h_pend    = r_h_vld && r_h_last;
    assign w_h_flush   = w_h_pend && w_o_free && w_len_free;
    assign w_fwd_state = (r_state == BODY) || (r_state == FIRST_SEQ);
    // A closed byte waiting in H must leave before anything else is taken.
    assign w_s_rdy     = w_h_pend ? w_h_flush : (!(r_h_vld && w_fwd_state) || w_o_free);
    assign w_acc       = s_tvalid && w_s_rdy;
    assign w_h_to_o    = w_h_flush || (w_push && r_h_vld && !r_h_last);

    assign s_tready      = w_s_rdy;
    assign m_tvalid      = r_o_vld;
    assign m_tdata       = r_o_dat;
    assign m_tlast       = r_o_last;
    assign m_tuser       = r_o_user;
    assign length_tvalid = r_len_vld;
    assign length_tdata  = r_len_dat;
    assign drop_count    = r_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_abort     = 1'b0;
        w_drop_h    = 1'b0;
        w_drop_inc  = 1'b0;
        w_start     = 1'b0;
        w_seq_init  = 1'b0;
        w_seq_inc   = 1'b0;
        if (w_acc) begin
            case (r_state)
                IDLE: begin
                    if (s_tlast) begin
                        w_drop_inc = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_push      = 1'b1;
                        w_state_nxt = FIRST_SEQ;
                    end
                end
                FIRST_SEQ: begin
                    if (s_tdata == 8'd0) begin
                        w_push = 1'b1;
                        if (s_tlast) begin
                            w_push_last = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_seq_init  = 1'b1;
                            w_state_nxt = BODY;
                        end
                    end else begin
                        w_drop_h    = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = s_tlast ? IDLE : DISCARD;
                    end
                end
                BODY: begin
                    if (r_fc == 16'hFFFF) begin
                        w_abort     = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = s_tlast ? IDLE : DISCARD;
                    end else begin
                        w_push = 1'b1;
                        if (r_sc == SC_LAST) begin
                            w_state_nxt = CONT_SRC;
                        end else if (s_tlast) begin
                            w_push_last = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                CONT_SRC: begin
                    if (s_tdata != r_src || s_tlast) begin
                        w_abort     = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = s_tlast ? IDLE : DISCARD;
                    end else begin
                        w_state_nxt = CONT_SEQ;
                    end
                end
                CONT_SEQ: begin
                    if (s_tdata != r_exp_seq || s_tlast) begin
                        w_abort     = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = s_tlast ? IDLE : DISCARD;
                    end else begin
                        w_seq_inc   = 1'b1;
                        w_state_nxt = BODY;
                    end
                end
                DISCARD: begin
                    if (s_tlast) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_vld   <= 1'b0;
            r_h_last  <= 1'b0;
            r_h_user  <= 1'b0;
            r_h_dat   <= 8'd0;
            r_o_vld   <= 1'b0;
            r_o_last  <= 1'b0;
            r_o_user  <= 1'b0;
            r_o_dat   <= 8'd0;
            r_len_vld <= 1'b0;
            r_len_dat <= 16'd0;
            r_drop    <= 16'd0;
            r_sc      <= '0;
            r_fc      <= 16'd0;
            r_exp_seq <= 8'd0;
            r_src     <= 8'd0;
        end else begin
            if (w_push) begin
                r_h_vld  <= 1'b1;
                r_h_dat  <= s_tdata;
                r_h_last <= w_push_last;
                r_h_user <= 1'b0;
            end else if (w_abort) begin
                r_h_last <= 1'b1;
                r_h_user <= 1'b1;
            end else if (w_drop_h || w_h_flush) begin
                r_h_vld  <= 1'b0;
                r_h_last <= 1'b0;
                r_h_user <= 1'b0;
            end

            if (w_h_to_o) begin
                r_o_vld  <= 1'b1;
                r_o_dat  <= r_h_dat;
                r_o_last <= r_h_last;
                r_o_user <= r_h_user;
            end else if (m_tready) begin
                r_o_vld  <= 1'b0;
                r_o_last <= 1'b0;
                r_o_user <= 1'b0;
            end

            // fc is stable while a closed byte waits, so it is the frame length here.
            if (w_h_flush) begin
                r_len_vld <= 1'b1;
                r_len_dat <= r_fc;
            end else if (length_tready) begin
                r_len_vld <= 1'b0;
            end

            if (w_drop_inc) begin
                r_drop <= r_drop + 16'd1;
            end

            if (w_acc) begin
                if (s_tlast || r_sc == SC_LAST) begin
                    r_sc <= '0;
                end else begin
                    r_sc <= r_sc + 1'b1;
                end
            end

            if (w_start) begin
                r_fc  <= 16'd1;
                r_src <= s_tdata;
            end else if (w_push) begin
                r_fc <= r_fc + 16'd1;
            end

            if (w_seq_init) begin
                r_exp_seq <= 8'd1;
            end else if (w_seq_inc) begin
                r_exp_seq <= r_exp_seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_frag_reassemble.sv
// Directed bench for udp_frag_reassemble: expected bytes and lengths are queued at stimulus time, a monitor pops and compares.
module tb_udp_frag_reassemble;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tuser;
    logic        length_tvalid;
    logic        length_tready;
    logic [15:0] length_tdata;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;
    int exp_drop = 0;
    bit bp_en    = 1'b0;
    bit stuck    = 1'b0;

    logic [9:0]  exp_q[$];
    logic [15:0] len_q[$];

    udp_frag_reassemble #(.NMAX(1024)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .s_tlast       (s_tlast),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .length_tvalid (length_tvalid),
        .length_tready (length_tready),
        .length_tdata  (length_tdata),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Sink-side ready pattern changes just after each rising edge.
    initial begin
        m_tready      = 1'b0;
        length_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_tready      = 1'($urandom_range(0, 1));
                length_tready = 1'($urandom_range(0, 1));
            end else begin
                m_tready      = 1'b1;
                length_tready = 1'b1;
            end
        end
    end

    initial begin
        logic [9:0]  e;
        logic [15:0] l;
        forever begin
            @(negedge clk);
            if (!reset && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m_byte unexpected actual=0x%0h expected=none", {m_tuser, m_tlast, m_tdata});
                end else begin
                    e = exp_q.pop_front();
                    chk("m_byte{user,last,data}", 32'({m_tuser, m_tlast, m_tdata}), 32'(e));
                end
            end
            if (!reset && length_tvalid && length_tready) begin
                if (len_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL length unexpected actual=%0d expected=none", length_tdata);
                end else begin
                    l = len_q.pop_front();
                    chk("length", 32'(length_tdata), 32'(l));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit done;
        done = 1'b0;
        if (stuck) return;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) begin
            stuck = 1'b1;
            checks++;
            failures++;
            $display("FAIL s_tready_timeout actual=stalled expected=accept data=0x%0h", d);
        end
    endtask

    task automatic send_sub(input logic [7:0] src, input logic [7:0] seq, input int n, input logic [7:0] base);
        logic [7:0] b;
        send_byte(src, n == 1);
        if (n > 1) send_byte(seq, n == 2);
        for (int j = 2; j < n; j++) begin
            b = base + 8'(j - 2);
            send_byte(b, j == n - 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic exp_push(input logic [7:0] d, input logic last, input logic user);
        exp_q.push_back({user, last, d});
    endtask

    task automatic exp_data(input logic [7:0] base, input int cnt, input logic last_end, input logic user_end);
        logic [7:0] b;
        for (int j = 0; j < cnt; j++) begin
            b = base + 8'(j);
            if (j == cnt - 1) exp_push(b, last_end, user_end);
            else exp_push(b, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || len_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain bytes_left=%0d lengths_left=%0d expected=0", name, exp_q.size(), len_q.size());
        end
    endtask

    initial begin
        int tot;
        int nsub;
        int sl;
        logic [7:0] base;

        reset    = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 8'd0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tuser", 32'(m_tuser), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_length_tvalid", 32'(length_tvalid), 32'd0);
        chk("rst_length_tdata", 32'(length_tdata), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single 10-byte sub-frame.
        exp_push(8'h05, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'h00, 8, 1'b1, 1'b0);
        len_q.push_back(16'd10);
        send_sub(8'h05, 8'h00, 10, 8'h00);
        wait_drain("single");
        chk("single_drop", 32'(drop_count), 32'(exp_drop));

        // 1024 + 300 byte sub-frames joined into one 1322-byte frame.
        exp_push(8'h05, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'h10, 1022, 1'b0, 1'b0);
        exp_data(8'h20, 298, 1'b1, 1'b0);
        len_q.push_back(16'd1322);
        send_sub(8'h05, 8'h00, 1024, 8'h10);
        send_sub(8'h05, 8'h01, 300, 8'h20);
        wait_drain("two_sub");
        chk("two_sub_drop", 32'(drop_count), 32'(exp_drop));

        // Sequence gap aborts after 1024 bytes; next clean frame still passes.
        exp_push(8'h05, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'h30, 1022, 1'b1, 1'b1);
        len_q.push_back(16'd1024);
        exp_drop++;
        send_sub(8'h05, 8'h00, 1024, 8'h30);
        send_sub(8'h05, 8'h02, 20, 8'h40);
        exp_push(8'h05, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'h50, 4, 1'b1, 1'b0);
        len_q.push_back(16'd6);
        send_sub(8'h05, 8'h00, 6, 8'h50);
        wait_drain("seq_gap");
        chk("seq_gap_drop", 32'(drop_count), 32'(exp_drop));

        // Runt in IDLE, then a first sub-frame with a nonzero sequence.
        exp_drop += 2;
        send_sub(8'h09, 8'h00, 1, 8'h00);
        send_sub(8'h05, 8'h07, 8, 8'h60);
        wait_drain("runt");
        chk("runt_drop", 32'(drop_count), 32'(exp_drop));

        // Frame ending on an exact NMAX boundary is aborted by a following seq-0 header.
        exp_push(8'h06, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'h70, 1022, 1'b1, 1'b1);
        len_q.push_back(16'd1024);
        exp_drop++;
        send_sub(8'h06, 8'h00, 1024, 8'h70);
        send_sub(8'h06, 8'h00, 10, 8'h80);
        exp_push(8'h06, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'h90, 1, 1'b1, 1'b0);
        len_q.push_back(16'd3);
        send_sub(8'h06, 8'h00, 3, 8'h90);
        // Minimal 2-byte frame: the sequence byte itself is last.
        exp_push(8'h07, 1'b0, 1'b0);
        exp_push(8'h00, 1'b1, 1'b0);
        len_q.push_back(16'd2);
        send_sub(8'h07, 8'h00, 2, 8'h00);
        wait_drain("boundary");
        chk("boundary_drop", 32'(drop_count), 32'(exp_drop));

        // Random backpressure on five multi-sub-frame frames.
        bp_en = 1'b1;
        for (int f = 0; f < 5; f++) begin
            nsub = (f == 2) ? 3 : 2;
            tot  = 2;
            exp_push(8'(8'h10 + f), 1'b0, 1'b0);
            exp_push(8'h00, 1'b0, 1'b0);
            for (int s = 0; s < nsub; s++) begin
                sl   = (s == nsub - 1) ? (40 + f * 50) : 1024;
                base = 8'(f * 16 + s * 64);
                exp_data(base, sl - 2, s == nsub - 1, 1'b0);
                tot += sl - 2;
            end
            len_q.push_back(16'(tot));
            for (int s = 0; s < nsub; s++) begin
                sl   = (s == nsub - 1) ? (40 + f * 50) : 1024;
                base = 8'(f * 16 + s * 64);
                send_sub(8'(8'h10 + f), 8'(s), sl, base);
            end
        end
        wait_drain("backpressure");
        chk("backpressure_drop", 32'(drop_count), 32'(exp_drop));
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a body.
        exp_push(8'h03, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'hA0, 18, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int j = 0; j < 18; j++) send_byte(8'(8'hA0 + j), 1'b0);
        s_tvalid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midframe_held_bytes", 32'(exp_q.size()), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("mid_rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("mid_rst_length_tvalid", 32'(length_tvalid), 32'd0);
        chk("mid_rst_drop_count", 32'(drop_count), 32'd0);
        exp_q.delete();
        len_q.delete();
        exp_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_push(8'h03, 1'b0, 1'b0);
        exp_push(8'h00, 1'b0, 1'b0);
        exp_data(8'hB0, 10, 1'b1, 1'b0);
        len_q.push_back(16'd12);
        send_sub(8'h03, 8'h00, 12, 8'hB0);
        wait_drain("after_reset");
        chk("after_reset_drop", 32'(drop_count), 32'(exp_drop));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
